pico_io_resp: RTL and testbench

Port-mapped I/O responder for the KCPSM3 (PicoBlaze) port bus: the peripheral end of the processor's `port_id`/`in_port`/`out_port`/strobe protocol. It debounces eight slide switches, records switch-change events in flag bits, drives an 8-bit LED register, and raises a KCPSM3 interrupt held until `interrupt_ack`. It sits beside the processor/ROM pair in a top-level system, replacing direct wiring of `sw` to `in_port` and `out_port` to the LEDs.

---
 rtl/pico_io_pkg.sv | 16 +
 rtl/pico_io_resp_if.sv | 25 ++
 rtl/sw_debounce.sv | 57 +++++
 rtl/pico_io_resp.sv | 99 +++++++++
 tb/tb_pico_io_resp.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pico_io_pkg.sv
// Shared constants for the KCPSM3 port-mapped I/O responder.
//   DW        : port bus data width
//   OFS_*     : register offsets within the decoded 8-port window
package pico_io_pkg;

  localparam int unsigned DW = 8;

  typedef logic [DW-1:0] data_t;

  localparam logic [2:0] OFS_SW   = 3'd0;  // debounced switches (R)
  localparam logic [2:0] OFS_FLAG = 3'd1;  // change flags (R/W1C)
  localparam logic [2:0] OFS_MASK = 3'd2;  // interrupt mask (R/W)
  localparam logic [2:0] OFS_LED  = 3'd3;  // LED register (R/W)
  localparam logic [2:0] OFS_RAW  = 3'd4;  // synchronized raw switches (R)

endpackage

// File: rtl/pico_io_resp_if.sv
// KCPSM3 port bus bundle.
//   master : processor side (drives address, write data, strobes, ack)
//   slave  : peripheral side (drives read data and interrupt)
interface pico_io_resp_if;
  import pico_io_pkg::*;

  data_t port_id;
  data_t out_port;
  logic  write_strobe;
  logic  read_strobe;
  data_t in_port;
  logic  interrupt;
  logic  interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );

endinterface

// File: rtl/sw_debounce.sv
// One-bit switch conditioner: 2-FF synchronizer followed by a stability
// counter that only lets db follow s2 after DB_CYCLES mismatched cycles.
//   clk, reset : system clock, synchronous active-high reset
//   sw_i       : raw asynchronous switch
//   s2_o       : synchronized raw switch
//   db_o       : debounced switch
//   chg_c_o    : combinational pulse, high in the cycle before db_o toggles
module sw_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic s2_o,
  output logic db_o,
  output logic chg_c_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES);

  logic          s1_q, s2_q, db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mis_c, expire_c;

  // Counter holds the number of mismatched cycles already seen; the
  // DB_CYCLES-th one updates db instead, so it tops out at DB_CYCLES-1.
  always_comb begin
    mis_c    = (s2_q != db_q);
    expire_c = mis_c && (cnt_q == CW'(DB_CYCLES - 1));
    db_d     = db_q;
    cnt_d    = '0;
    if (expire_c) begin
      db_d = s2_q;
    end else if (mis_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= sw_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign s2_o    = s2_q;
  assign db_o    = db_q;
  assign chg_c_o = expire_c;

endmodule

// File: rtl/pico_io_resp.sv
// KCPSM3 port-bus peripheral: debounced switches with change flags,
// maskable interrupt held until interrupt_ack, and an LED register.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : KCPSM3 port bus (slave side)
//   sw_i       : raw asynchronous switches
//   led_o      : LED register
module pico_io_resp
  import pico_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000,
  parameter logic [7:0]  BASE_ADDR = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  pico_io_resp_if.slave   bus,
  input  logic [DW-1:0]   sw_i,
  output logic [DW-1:0]   led_o
);

  data_t db_c, raw_c, chg_c;
  data_t flags_q, flags_d;
  data_t mask_q,  mask_d;
  data_t led_q,   led_d;
  data_t rdat_q,  rdat_d;
  logic  irq_q,   irq_d;
  logic  hit_c, wr_c;
  logic [2:0] ofs_c;

  for (genvar i = 0; i < int'(DW); i++) begin : g_db
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .sw_i    (sw_i[i]),
      .s2_o    (raw_c[i]),
      .db_o    (db_c[i]),
      .chg_c_o (chg_c[i])
    );
  end

  // Decode, register updates, read mux and interrupt next-state.
  always_comb begin
    hit_c   = (bus.port_id[7:3] == BASE_ADDR[7:3]);
    ofs_c   = bus.port_id[2:0];
    wr_c    = bus.write_strobe && hit_c;
    flags_d = flags_q;
    mask_d  = mask_q;
    led_d   = led_q;
    rdat_d  = '0;
    irq_d   = 1'b0;

    if (wr_c && (ofs_c == OFS_FLAG)) flags_d = flags_q & ~bus.out_port;
    flags_d = flags_d | chg_c;  // a new event beats a simultaneous clear

    if (wr_c && (ofs_c == OFS_MASK)) mask_d = bus.out_port;
    if (wr_c && (ofs_c == OFS_LED))  led_d  = bus.out_port;

    if (hit_c) begin
      case (ofs_c)
        OFS_SW:   rdat_d = db_c;
        OFS_FLAG: rdat_d = flags_q;
        OFS_MASK: rdat_d = mask_q;
        OFS_LED:  rdat_d = led_q;
        OFS_RAW:  rdat_d = raw_c;
        default:  rdat_d = '0;
      endcase
    end

    // Ack forces one low cycle; the request is re-evaluated afterwards.
    if (!bus.interrupt_ack) irq_d = |(flags_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      mask_q  <= '0;
      led_q   <= '0;
      rdat_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      mask_q  <= mask_d;
      led_q   <= led_d;
      rdat_q  <= rdat_d;
      irq_q   <= irq_d;
    end
  end

  // KCPSM3 never issues both strobes in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.read_strobe && bus.write_strobe));
    end
  end

  assign bus.in_port   = rdat_q;
  assign bus.interrupt = irq_q;
  assign led_o         = led_q;

endmodule

// File: tb/tb_pico_io_resp.sv
module tb_pico_io_resp;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] led;
  int         n_cmp = 0;
  int         n_bad = 0;

  pico_io_resp_if bus ();

  pico_io_resp #(.DB_CYCLES(4), .BASE_ADDR(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .sw_i  (sw),
    .led_o (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.port_id      = addr;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    bus.port_id = addr;
    tick();
    chk(tag, bus.in_port, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset             = 1'b1;
    sw                = 8'hFF;
    bus.port_id       = 8'h00;
    bus.out_port      = 8'h00;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;

    // Reset with switches high
    ticks(3);
    chk("rst_in_port", bus.in_port, 8'h00);
    chk("rst_led", led, 8'h00);
    chk("rst_irq", {7'd0, bus.interrupt}, 8'h00);

    // db rises at edge 6 after release; in_port shows it one edge later
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) chk("pwrup_db_early", bus.in_port, 8'h00);
      if (i == 7) chk("pwrup_db", bus.in_port, 8'hFF);
    end
    rd(8'h01, 8'hFF, "pwrup_flags");
    chk("pwrup_irq", {7'd0, bus.interrupt}, 8'h00);

    // Settle switches low and clear flags
    sw = 8'h00;
    ticks(10);
    wr(8'h01, 8'hFF);
    rd(8'h01, 8'h00, "w1c_all");
    rd(8'h00, 8'h00, "db_low");

    // LED write / readback, write to read-only port 0 ignored
    wr(8'h03, 8'hA5);
    chk("led_write", led, 8'hA5);
    rd(8'h03, 8'hA5, "led_readback");
    wr(8'h00, 8'h5A);
    rd(8'h00, 8'h00, "ro_port0");

    // 3-cycle glitch on sw[0] is filtered
    sw = 8'h01;
    ticks(3);
    sw = 8'h00;
    ticks(6);
    rd(8'h00, 8'h00, "glitch_db");
    rd(8'h01, 8'h00, "glitch_flag");

    // Stable high: db[0] changes exactly 6 edges after sw
    bus.port_id = 8'h00;
    sw = 8'h01;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) chk("hold_db_early", bus.in_port, 8'h00);
      if (i == 7) chk("hold_db", bus.in_port, 8'h01);
    end
    ticks(3);
    rd(8'h01, 8'h01, "hold_flag");

    // Interrupt path
    wr(8'h01, 8'h01);
    rd(8'h01, 8'h00, "w1c_bit0");
    wr(8'h02, 8'h01);
    rd(8'h02, 8'h01, "mask_rb");
    chk("irq_idle", {7'd0, bus.interrupt}, 8'h00);
    bus.port_id = 8'h01;
    sw = 8'h00;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) begin
        chk("irq_flag_early", bus.in_port, 8'h00);
        chk("irq_early", {7'd0, bus.interrupt}, 8'h00);
      end
      if (i == 7) begin
        chk("irq_flag", bus.in_port, 8'h01);
        chk("irq_rise", {7'd0, bus.interrupt}, 8'h01);
      end
    end
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    chk("irq_ack", {7'd0, bus.interrupt}, 8'h00);
    tick();
    chk("irq_reassert", {7'd0, bus.interrupt}, 8'h01);
    wr(8'h01, 8'h01);
    tick();
    chk("irq_w1c", {7'd0, bus.interrupt}, 8'h00);
    rd(8'h01, 8'h00, "flags_w1c");
    ticks(3);
    chk("irq_stays_low", {7'd0, bus.interrupt}, 8'h00);

    // W1C on the same edge as db[2] changes: set wins
    sw = 8'h04;
    ticks(5);
    wr(8'h01, 8'h04);
    rd(8'h01, 8'h04, "set_wins");
    wr(8'h01, 8'h04);
    rd(8'h01, 8'h00, "w1c_bit2");
    rd(8'h00, 8'h04, "db_bit2");
    rd(8'h04, 8'h04, "raw_bit2");
    chk("irq_unmasked", {7'd0, bus.interrupt}, 8'h00);

    // Unmapped offsets, foreign address
    rd(8'h05, 8'h00, "rd_ofs5");
    rd(8'h07, 8'h00, "rd_ofs7");
    rd(8'h10, 8'h00, "rd_foreign");
    wr(8'h13, 8'hFF);
    chk("wr_foreign_led", led, 8'hA5);
    rd(8'h03, 8'hA5, "led_kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
